bsg_expand_bitmask_serial: RTL and testbench

BSG_EXPAND_BITMASK_SERIAL -- requirements
Module: bsg_expand_bitmask_serial

---
 rtl/bsg_expand_bitmask_pkg.sv | 18 +
 rtl/bsg_expand_bitmask_core.sv | 29 ++
 rtl/bsg_expand_bitmask_serial.sv | 97 +++++++++
 tb/tb_bsg_expand_bitmask_serial.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_expand_bitmask_pkg.sv
// Purpose: shared encodings for the serial bitmask expander.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bsg_expand_bitmask_pkg;

  // How each mask bit fills its expand_p-wide output field.
  typedef enum logic {
    MODE_REPLICATE  = 1'b0,  // every bit of the field copies the mask bit
    MODE_FIRST_ONLY = 1'b1   // only the lowest bit of the field carries it
  } mode_e;

  // Controller states: IDLE waits for a mask, BUSY streams its beats.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_expand_bitmask_core.sv
// Purpose: combinational expansion of an in_width_p mask into in_width_p*expand_p bits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows its inputs.
//
// Ports:
//   data_i : mask to expand
//   mode_i : expansion mode (see mode_e)
//   data_o : full expansion, field i occupies bits [i*expand_p +: expand_p]
module bsg_expand_bitmask_core
  import bsg_expand_bitmask_pkg::*;
#(
  parameter int in_width_p = 16,
  parameter int expand_p   = 32
) (
  input  logic [in_width_p-1:0]          data_i,
  input  logic                           mode_i,
  output logic [in_width_p*expand_p-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < in_width_p; i++) begin
      for (int k = 0; k < expand_p; k++) begin
        data_o[i*expand_p + k] = data_i[i] & ((mode_i == MODE_REPLICATE) || (k == 0));
      end
    end
  end

endmodule

// File: rtl/bsg_expand_bitmask_serial.sv
// Purpose: expand a mask by expand_p and stream the result as out_width_p-wide beats.
// Latency: first beat valid the cycle after acceptance; one beat per yumi_i.
// Backpressure: beats hold while yumi_i=0; next mask accepted on the last-beat yumi_i (no bubble).
//
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   v_i, data_i, mode_i, ready_o : mask input handshake (accept on v_i & ready_o)
//   v_o, data_o, last_o, yumi_i  : beat output handshake (consume on yumi_i)
module bsg_expand_bitmask_serial
  import bsg_expand_bitmask_pkg::*;
#(
  parameter int in_width_p  = 16,
  parameter int expand_p    = 32,
  parameter int out_width_p = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [in_width_p-1:0]  data_i,
  input  logic                   mode_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [out_width_p-1:0] data_o,
  output logic                   last_o,
  input  logic                   yumi_i
);

  localparam int full_width_lp = in_width_p * expand_p;
  localparam int beats_lp      = full_width_lp / out_width_p;
  localparam int cnt_width_lp  = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(beats_lp - 1);

  if ((full_width_lp % out_width_p) != 0) begin : g_bad_width
    $error("in_width_p*expand_p must be a multiple of out_width_p");
  end

  state_e                  state_r, state_n;
  logic [cnt_width_lp-1:0] cnt_r;
  logic [in_width_p-1:0]   mask_r;
  logic                    mode_r;
  logic                    accept;
  logic                    advance;

  logic [full_width_lp-1:0]                  full_w;
  logic [beats_lp-1:0][out_width_p-1:0]      beat_arr;

  bsg_expand_bitmask_core #(
    .in_width_p (in_width_p),
    .expand_p   (expand_p)
  ) core (
    .data_i (mask_r),
    .mode_i (mode_r),
    .data_o (full_w)
  );

  // Reshape the expansion into beats; the counter picks the current one.
  // Captured mask resets to 0, so data_o reads 0 straight out of reset.
  assign beat_arr = full_w;
  assign data_o   = beat_arr[cnt_r];

  always_comb begin
    state_n = state_r;
    v_o     = (state_r == BUSY);
    last_o  = v_o & (cnt_r == last_cnt_lp);
    // Gated by reset_i because the async reset already shows IDLE while held.
    ready_o = ~reset_i & ((state_r == IDLE) | ((state_r == BUSY) & last_o & yumi_i));
    accept  = v_i & ready_o;
    // yumi_i without v_o is ignored so a protocol slip cannot move state.
    advance = v_o & yumi_i & ~last_o;
    case (state_r)
      IDLE: if (accept) state_n = BUSY;
      BUSY: if (last_o & yumi_i) state_n = accept ? BUSY : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      mask_r  <= '0;
      mode_r  <= MODE_REPLICATE;
    end else begin
      state_r <= state_n;
      if (accept) begin
        mask_r <= data_i;
        mode_r <= mode_i;
        cnt_r  <= '0;
      end else if (advance) begin
        cnt_r  <= cnt_r + cnt_width_lp'(1);
      end
    end
  end

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_expand_bitmask_serial.sv
`timescale 1ns/1ps
// Purpose: scoreboard bench for bsg_expand_bitmask_serial (8-beat and 1-beat instances).
// Latency: expects first beat the cycle after acceptance.
// Backpressure: random and continuous yumi_i patterns, back-to-back masks, async reset mid-mask.
module tb_bsg_expand_bitmask_serial;

  typedef struct packed {
    logic [63:0] dat;
    logic        last;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        reset_i;

  // 8-beat instance
  logic        v_i, mode_i, ready_o, v_o, last_o, yumi_i;
  logic [15:0] data_i;
  logic [63:0] data_o;

  // 1-beat instance
  logic         v_i2, mode_i2, ready_o2, v_o2, last_o2, yumi_i2;
  logic [15:0]  data_i2;
  logic [511:0] data_o2;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t        sb[$];
  logic [511:0] sb2[$];

  logic        stall_en = 1'b0;
  logic        hold_vld = 1'b0;
  logic [63:0] hold_dat;
  logic        hold_last;

  always #5 clk_i = ~clk_i;

  bsg_expand_bitmask_serial #(.in_width_p(16), .expand_p(32), .out_width_p(64)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .mode_i  (mode_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .last_o  (last_o),
    .yumi_i  (yumi_i)
  );

  bsg_expand_bitmask_serial #(.in_width_p(16), .expand_p(32), .out_width_p(512)) dut2 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i2),
    .data_i  (data_i2),
    .mode_i  (mode_i2),
    .ready_o (ready_o2),
    .v_o     (v_o2),
    .data_o  (data_o2),
    .last_o  (last_o2),
    .yumi_i  (yumi_i2)
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference expansion written from the definition: output bit g takes mask bit g/32.
  function automatic logic [511:0] expand_model(input logic [15:0] m, input logic md);
    logic [511:0] r;
    for (int g = 0; g < 512; g++) r[g] = m[g/32] & (!md || (g % 32 == 0));
    return r;
  endfunction

  task automatic push_beats(input logic [511:0] full);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.dat  = full[k*64 +: 64];
      b.last = (k == 7);
      sb.push_back(b);
    end
  endtask

  // Present a mask, wait (bounded) for ready_o, queue its beats, release after the accept edge.
  task automatic send(input logic [15:0] m, input logic md, input logic [511:0] full);
    int n;
    n = 0;
    v_i = 1'b1; data_i = m; mode_i = md;
    @(negedge clk_i);
    while (!ready_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    if (!ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: ready_o never rose for mask %h", m);
      v_i = 1'b0;
      return;
    end
    push_beats(full);
    @(posedge clk_i); #1;
    v_i = 1'b0;
    chk("v_o_latency1", v_o, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || v_o) && n < 300) begin
      n++;
      @(posedge clk_i);
    end
    #1;
    if (sb.size() != 0 || v_o) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, v_o=%0b", sb.size(), v_o);
      sb.delete();
    end
  endtask

  // Consumer drivers: yumi only while a beat is presented.
  always @(posedge clk_i) begin
    #1;
    yumi_i  = v_o & (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
    yumi_i2 = v_o2;
  end

  // Monitor for the 8-beat instance: pop on each consumed beat, check stability on stalls.
  always @(negedge clk_i) begin
    beat_t e;
    if (hold_vld && !reset_i) begin
      chk("stall_data_stable", data_o, hold_dat);
      chk("stall_last_stable", last_o, hold_last);
    end
    hold_vld = 1'b0;
    if (v_o && !reset_i) begin
      if (yumi_i) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat: got %h with nothing expected", data_o);
        end else begin
          e = sb.pop_front();
          chk("beat_data", data_o, e.dat);
          chk("beat_last", last_o, e.last);
        end
      end else begin
        hold_vld  = 1'b1;
        hold_dat  = data_o;
        hold_last = last_o;
      end
    end
  end

  // Monitor for the single-beat instance.
  always @(negedge clk_i) begin
    logic [511:0] e2;
    if (v_o2 && yumi_i2 && !reset_i) begin
      if (sb2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL extra_beat_wide: unexpected beat %h", data_o2);
      end else begin
        e2 = sb2.pop_front();
        chk("wide_beat_data", data_o2, e2);
        chk("wide_beat_last", last_o2, 1'b1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1;
    v_i = 1'b0; data_i = '0; mode_i = 1'b0; yumi_i = 1'b0;
    v_i2 = 1'b0; data_i2 = '0; mode_i2 = 1'b0; yumi_i2 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_ready_low", ready_o, 1'b0);
    chk("rst_v_o", v_o, 1'b0);
    chk("rst_last_o", last_o, 1'b0);
    chk("rst_data_o", data_o, 64'h0);
    chk("rst_ready2_low", ready_o2, 1'b0);
    #2 reset_i = 1'b0;
    #1;
    chk("post_rst_ready", ready_o, 1'b1);
    chk("post_rst_ready2", ready_o2, 1'b1);
    @(posedge clk_i); #1;

    // Replicate: fields 0 and 15 set
    send(16'h8001, 1'b0, {32'hFFFF_FFFF, 448'd0, 32'hFFFF_FFFF});
    drain();

    // First-only: bits 0 and 480
    send(16'h8001, 1'b1, {31'd0, 1'b1, 479'd0, 1'b1});
    drain();

    // Random stalls
    stall_en = 1'b1;
    send(16'hA5C3, 1'b0, expand_model(16'hA5C3, 1'b0));
    drain();
    send(16'h3C96, 1'b1, expand_model(16'h3C96, 1'b1));
    drain();
    stall_en = 1'b0;

    // Back-to-back: second mask held until the last-beat yumi
    send(16'h8001, 1'b0, {32'hFFFF_FFFF, 448'd0, 32'hFFFF_FFFF});
    send(16'hFFFF, 1'b0, {512{1'b1}});
    chk("b2b_beat0_ones", data_o, {64{1'b1}});
    chk("b2b_last_low", last_o, 1'b0);
    drain();

    // Async reset during beat 3
    send(16'hFFFF, 1'b0, {512{1'b1}});
    repeat (3) @(posedge clk_i);
    #2;
    chk("beat3_before_rst", data_o, {64{1'b1}});
    reset_i = 1'b1;
    yumi_i  = 1'b0;
    hold_vld = 1'b0;
    #1;
    chk("midrst_v_o", v_o, 1'b0);
    chk("midrst_last_o", last_o, 1'b0);
    chk("midrst_ready", ready_o, 1'b0);
    reset_i = 1'b0;
    sb.delete();
    #1;
    chk("rel_ready", ready_o, 1'b1);
    send(16'h0001, 1'b0, {448'd0, 64'h0000_0000_FFFF_FFFF});
    drain();

    // Single-beat instance, back-to-back under continuous yumi
    @(posedge clk_i); #1;
    v_i2 = 1'b1; data_i2 = 16'h8001; mode_i2 = 1'b0;
    sb2.push_back({32'hFFFF_FFFF, 448'd0, 32'hFFFF_FFFF});
    @(negedge clk_i);
    chk("wide_ready_idle", ready_o2, 1'b1);
    @(posedge clk_i); #1;
    data_i2 = 16'h1234; mode_i2 = 1'b1;
    sb2.push_back(expand_model(16'h1234, 1'b1));
    @(negedge clk_i);
    chk("wide_ready_b2b", ready_o2, 1'b1);
    @(posedge clk_i); #1;
    v_i2 = 1'b0;
    chk("wide_v_o_no_bubble", v_o2, 1'b1);
    repeat (3) @(posedge clk_i);
    #1;
    if (sb2.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wide_drain: %0d beats outstanding", sb2.size());
    end
    chk("wide_idle_v_o", v_o2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
